// File: rtl/mem_step_pkg.sv
// ============================================================================
//  Module   : mem_step_pkg
//  Brief    : Shared types and defaults for the memory step controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package mem_step_pkg;

    localparam int ADDR_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CNT = 2'd1,
        HELD      = 2'd2,
        REL_CNT   = 2'd3
    } db_state_e;

    // Bits needed for a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
//  Module   : btn_debounce
//  Brief    : 2-flop synchronizer plus debounce FSM; one press pulse per press.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module btn_debounce
    import mem_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic press_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    db_state_e        state_q;
    db_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_CNT;
                    cnt_d   = '0;
                end
            end
            PRESS_CNT: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == c_cnt_max) begin
                    state_d = HELD;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    state_d = REL_CNT;
                    cnt_d   = '0;
                end
            end
            REL_CNT: begin
                // A bounce back high during release returns to HELD with no new pulse.
                if (sync2_q) begin
                    state_d = HELD;
                end else if (cnt_q == c_cnt_max) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/mem_step_ctrl.sv
// ============================================================================
//  Module   : mem_step_ctrl
//  Brief    : Button/auto step strobe, wrapping word address and write qualify.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mem_step_ctrl
    import mem_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int AUTO_PERIOD     = 50000000,
    parameter int ADDR_W          = ADDR_W_DEFAULT
) (
    input  logic              Clk_100M,
    input  logic              Rst,
    input  logic              Btn_Step,
    input  logic              Btn_Clear,
    input  logic              Sw_Write,
    input  logic              Sw_Auto,
    output logic              Clk_Pulse,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_Write
);

    localparam int AUTO_W = cnt_width(AUTO_PERIOD);
    localparam logic [AUTO_W-1:0] c_auto_max = AUTO_W'(AUTO_PERIOD - 1);

    logic              step_press;
    logic              clear_press;
    logic              wr_sync1_q;
    logic              wr_sync2_q;
    logic              au_sync1_q;
    logic              au_sync2_q;
    logic [AUTO_W-1:0] auto_cnt_q;
    logic [AUTO_W-1:0] auto_cnt_d;
    logic              auto_hit;
    logic              step_req;
    logic              pulse_q;
    logic              pulse_d;
    logic              write_q;
    logic              write_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              clr_pend_q;
    logic              clr_pend_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk_i   (Clk_100M),
        .rst_i   (Rst),
        .raw_i   (Btn_Step),
        .press_o (step_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clear_db (
        .clk_i   (Clk_100M),
        .rst_i   (Rst),
        .raw_i   (Btn_Clear),
        .press_o (clear_press)
    );

    always_ff @(posedge Clk_100M) begin
        if (Rst) begin
            wr_sync1_q <= 1'b0;
            wr_sync2_q <= 1'b0;
            au_sync1_q <= 1'b0;
            au_sync2_q <= 1'b0;
            auto_cnt_q <= '0;
            pulse_q    <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            wr_sync1_q <= Sw_Write;
            wr_sync2_q <= wr_sync1_q;
            au_sync1_q <= Sw_Auto;
            au_sync2_q <= au_sync1_q;
            auto_cnt_q <= auto_cnt_d;
            pulse_q    <= pulse_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    always_comb begin
        auto_hit   = au_sync2_q && (auto_cnt_q == c_auto_max);
        auto_cnt_d = (!au_sync2_q || auto_hit) ? '0 : auto_cnt_q + AUTO_W'(1);
        step_req   = au_sync2_q ? auto_hit : step_press;

        pulse_d    = step_req;
        write_d    = step_req && wr_sync2_q;

        // A clear colliding with a step request is deferred one edge so the
        // step still presents the old address, then lands in place of the increment.
        clr_pend_d = 1'b0;
        addr_d     = addr_q;
        if (clear_press && step_req) begin
            clr_pend_d = 1'b1;
        end else if (clear_press || (pulse_q && clr_pend_q)) begin
            addr_d = '0;
        end else if (pulse_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    assign Clk_Pulse = pulse_q;
    assign Mem_Write = write_q;
    assign Mem_Addr  = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_step_ctrl.sv
// ============================================================================
//  Module   : tb_mem_step_ctrl
//  Brief    : Directed + randomized bench for mem_step_ctrl with reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_step_ctrl;

    localparam int N  = 4;
    localparam int P  = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bs  = 1'b0;
    logic          bc  = 1'b0;
    logic          sw  = 1'b0;
    logic          au  = 1'b0;
    logic          pulse;
    logic          write;
    logic [AW-1:0] addr;

    always #5 clk = ~clk;

    mem_step_ctrl #(
        .DEBOUNCE_CYCLES (N),
        .AUTO_PERIOD     (P),
        .ADDR_W          (AW)
    ) dut (
        .Clk_100M  (clk),
        .Rst       (rst),
        .Btn_Step  (bs),
        .Btn_Clear (bc),
        .Sw_Write  (sw),
        .Sw_Auto   (au),
        .Clk_Pulse (pulse),
        .Mem_Addr  (addr),
        .Mem_Write (write)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int tick_no = 0;
    int pulses = 0;
    int writes = 0;
    int last_paddr = -1;

    // Reference model: sync delay lines, debounced level with run-length
    // acceptance (N+1 consecutive opposite samples flip it), auto age counter.
    logic m_s1 [4];
    logic m_s2 [4];
    logic m_lvl [2];
    int   m_run [2];
    logic m_press [2];
    int   m_age;
    logic m_pulse;
    logic m_write;
    logic m_due;
    int   m_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (tick %0d)", tag, obs, exp, tick_no);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_s1[i] = 1'b0;
            m_s2[i] = 1'b0;
        end
        for (int b = 0; b < 2; b++) begin
            m_lvl[b]   = 1'b0;
            m_run[b]   = 0;
            m_press[b] = 1'b0;
        end
        m_age   = 0;
        m_pulse = 1'b0;
        m_write = 1'b0;
        m_due   = 1'b0;
        m_addr  = 0;
    endtask

    task automatic db_update(input int b, input logic v);
        m_press[b] = 1'b0;
        if (v == m_lvl[b]) begin
            m_run[b] = 0;
        end else begin
            m_run[b]++;
            if (m_run[b] == N + 1) begin
                m_lvl[b]   = v;
                m_run[b]   = 0;
                m_press[b] = v;
            end
        end
    endtask

    task automatic model_edge(input logic r, input logic [3:0] raw);
        logic a;
        logic w;
        logic req;
        logic clr;
        if (r) begin
            model_reset();
        end else begin
            a   = m_s2[3];
            w   = m_s2[2];
            req = a ? ((m_age % P) == P - 1) : m_press[0];
            clr = m_press[1];
            if (!(clr && req)) begin
                if (clr || m_due)
                    m_addr = 0;
                else if (m_pulse)
                    m_addr = (m_addr + 1) % (1 << AW);
            end
            m_due   = clr && req;
            m_pulse = req;
            m_write = req && w;
            m_age   = a ? m_age + 1 : 0;
            db_update(0, m_s2[0]);
            db_update(1, m_s2[1]);
            for (int i = 0; i < 4; i++) begin
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
        end
    endtask

    task automatic tick();
        logic [3:0] raw;
        logic       r;
        raw = {au, sw, bc, bs};
        r   = rst;
        @(posedge clk);
        #1;
        tick_no++;
        model_edge(r, raw);
        check("Clk_Pulse", 32'(pulse), 32'(m_pulse));
        check("Mem_Write", 32'(write), 32'(m_write));
        check("Mem_Addr",  32'(addr),  32'(m_addr));
        if (pulse === 1'b1) begin
            pulses++;
            last_paddr = int'(addr);
        end
        if (write === 1'b1) writes++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input int hold, input int gap);
        bs = 1'b1;
        ticks(hold);
        bs = 1'b0;
        ticks(gap);
    endtask

    initial begin
        int first;
        int rem_s;
        int rem_c;
        model_reset();

        // Reset state
        tick();
        check("reset Clk_Pulse", 32'(pulse), 32'd0);
        check("reset Mem_Write", 32'(write), 32'd0);
        check("reset Mem_Addr",  32'(addr),  32'd0);
        tick();
        rst = 1'b0;
        ticks(3);

        // Clean press: strobe appears after edge N+3
        bs = 1'b1;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (pulse === 1'b1 && first < 0) first = i;
        end
        check("t1 first pulse edge", 32'(first), 32'd7);
        check("t1 addr after step", 32'(addr), 32'd1);
        bs = 1'b0;
        ticks(10);

        // Bouncy press and release: one pulse timed from the stable level
        pulses = 0;
        bs = 1'b1; tick(); bs = 1'b0; tick(); bs = 1'b1; tick(); bs = 1'b0; tick();
        bs = 1'b1;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (pulse === 1'b1 && first < 0) first = i;
        end
        check("t2 first pulse edge", 32'(first), 32'd7);
        bs = 1'b0; tick(); bs = 1'b1; tick(); bs = 1'b0; tick(); bs = 1'b1; tick();
        bs = 1'b0;
        ticks(12);
        check("t2 pulse count", 32'(pulses), 32'd1);

        // Clear, then 64 write steps walking the full address range
        bc = 1'b1; ticks(7); bc = 1'b0; ticks(8);
        check("t3 addr after clear", 32'(addr), 32'd0);
        sw = 1'b1;
        pulses = 0;
        writes = 0;
        for (int p = 0; p < 64; p++) begin
            press(7, 7);
            check("t3 pulse addr", 32'(last_paddr), 32'(p));
        end
        check("t3 pulse count", 32'(pulses), 32'd64);
        check("t3 write count", 32'(writes), 32'd64);
        check("t3 addr wrapped", 32'(addr), 32'd0);
        sw = 1'b0;

        // Step and clear together from address 5
        for (int p = 0; p < 5; p++) press(7, 7);
        check("t4 addr before", 32'(addr), 32'd5);
        pulses = 0;
        bs = 1'b1; bc = 1'b1;
        ticks(8);
        bs = 1'b0; bc = 1'b0;
        ticks(8);
        check("t4 pulse count", 32'(pulses), 32'd1);
        check("t4 pulse addr", 32'(last_paddr), 32'd5);
        check("t4 addr after", 32'(addr), 32'd0);

        // Auto mode: pulses every P cycles, button presses ignored
        pulses = 0;
        au = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bs = (i < 48) && ((i % 16) < 10);
            tick();
        end
        check("t5 auto pulse count", 32'(pulses), 32'd7);
        bs = 1'b0;
        ticks(12);
        au = 1'b0;
        ticks(2);
        pulses = 0;
        ticks(20);
        check("t5 pulses after auto off", 32'(pulses), 32'd0);

        // Reset in the middle of a press
        bs = 1'b1;
        ticks(4);
        rst = 1'b1;
        tick();
        check("t6 reset Clk_Pulse", 32'(pulse), 32'd0);
        check("t6 reset Mem_Addr",  32'(addr),  32'd0);
        check("t6 reset Mem_Write", 32'(write), 32'd0);
        rst = 1'b0;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (pulse === 1'b1 && first < 0) first = i;
        end
        check("t6 first pulse edge", 32'(first), 32'd7);
        bs = 1'b0;
        ticks(10);

        // Randomized traffic on every input
        rem_s = 0;
        rem_c = 0;
        for (int i = 0; i < 600; i++) begin
            if (rem_s == 0) begin
                bs    = 1'($urandom_range(0, 1));
                rem_s = int'($urandom_range(1, 9));
            end
            if (rem_c == 0) begin
                bc    = ($urandom_range(0, 3) == 0);
                rem_c = int'($urandom_range(1, 9));
            end
            rem_s--;
            rem_c--;
            if ($urandom_range(0, 15) == 0) sw = ~sw;
            if ($urandom_range(0, 63) == 0) au = ~au;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        bs  = 1'b0;
        bc  = 1'b0;
        au  = 1'b0;
        ticks(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
